// File: rtl/bcd_ascii_pkg.sv
// Shared types, ASCII constants and digit encoding for the BCD-to-ASCII serialiser.
package bcd_ascii_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    TERM = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    logic [7:0] c;
    if (d <= 4'd9) begin
      c = ASCII_ZERO | {4'h0, d};
    end else begin
      c = ASCII_ERR;
    end
    return c;
  endfunction

endpackage

// File: rtl/lead_digit_enc.sv
// Priority encoder: index of the most significant non-zero nibble of a BCD word,
// 0 for an all-zero word. Invalid nibbles (10..15) count as non-zero.
module lead_digit_enc
  import bcd_ascii_pkg::*;
#(
  parameter  int DIGITS = 6,
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic [4*DIGITS-1:0] bcd,
  output logic [IW-1:0]       idx
);

  // Later (higher) non-zero digits override earlier ones.
  always_comb begin
    idx = {IW{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] != 4'h0) begin
        idx = IW'(k);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/bcd_ascii_tx.sv
// Serialises a packed BCD word to ASCII, MSD first, with leading-zero suppression.
// Define BCD_ASCII_CRLF_EN to append CR/LF after each word (m_last then marks LF).
module bcd_ascii_tx
  import bcd_ascii_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] s_bcd,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [7:0]          m_char,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W  = 4 * DIGITS;

  state_t          state, n_state;
  logic [IW-1:0]   idx, n_idx, lead;
  logic [W-1:0]    word, n_word;
  logic [7:0]      n_char;
  logic            n_valid, n_last;
  logic [IW-1:0]   idx_dec;

  function automatic logic [3:0] nibble(input logic [W-1:0] w, input logic [IW-1:0] i);
    logic [3:0] n;
    n = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i == IW'(k)) begin
        n = w[4*k +: 4];
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  lead_digit_enc #(.DIGITS(DIGITS)) u_lead (
    .bcd (s_bcd),
    .idx (lead)
  );

  assign s_ready = (state == IDLE);
  assign busy    = (state != IDLE);
  assign idx_dec = idx - IW'(1);

  // Next-state, digit index and output-register decode.
  always_comb begin
    n_state = state;
    n_idx   = idx;
    n_word  = word;
    n_char  = m_char;
    n_valid = m_valid;
    n_last  = m_last;
    case (state)
      IDLE: begin
        if (s_valid) begin
          n_word  = s_bcd;
          n_idx   = lead;
          n_char  = digit_to_ascii(nibble(s_bcd, lead));
          n_valid = 1'b1;
`ifdef BCD_ASCII_CRLF_EN
          n_last  = 1'b0;
`else
          n_last  = (lead == {IW{1'b0}});
`endif
          n_state = SEND;
        end else begin
          n_state = IDLE;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (idx != {IW{1'b0}}) begin
            n_idx  = idx_dec;
            n_char = digit_to_ascii(nibble(word, idx_dec));
`ifdef BCD_ASCII_CRLF_EN
            n_last = 1'b0;
`else
            n_last = (idx_dec == {IW{1'b0}});
`endif
          end else begin
`ifdef BCD_ASCII_CRLF_EN
            n_char  = ASCII_CR;
            n_last  = 1'b0;
            n_state = TERM;
`else
            n_valid = 1'b0;
            n_last  = 1'b0;
            n_state = IDLE;
`endif
          end
        end else begin
          n_state = SEND;
        end
      end
`ifdef BCD_ASCII_CRLF_EN
      TERM: begin
        if (m_ready) begin
          // CR is always followed by LF; LF's handshake ends the word.
          if (m_char == ASCII_CR) begin
            n_char = ASCII_LF;
            n_last = 1'b1;
          end else begin
            n_valid = 1'b0;
            n_last  = 1'b0;
            n_state = IDLE;
          end
        end else begin
          n_state = TERM;
        end
      end
`endif
      default: begin
        n_state = IDLE;
        n_valid = 1'b0;
        n_last  = 1'b0;
        n_idx   = {IW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= {IW{1'b0}};
      word    <= {W{1'b0}};
      m_char  <= 8'h00;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      state   <= n_state;
      idx     <= n_idx;
      word    <= n_word;
      m_char  <= n_char;
      m_valid <= n_valid;
      m_last  <= n_last;
    end
  end

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Randomised self-checking bench for bcd_ascii_tx against a character-queue model.
module tb_bcd_ascii_tx;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] s_bcd;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_char;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  bq_t  q;
  bq_t  log_chars;
  logic log_last[$];

  bcd_ascii_tx #(.DIGITS(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_bcd   (s_bcd),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_char  (m_char),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Characters a word must produce: strip leading zeros, map each digit.
  function automatic bq_t build(input logic [23:0] w);
    bq_t r;
    int lead = 0;
    for (int k = 0; k < 6; k++) if (((w >> (4*k)) & 24'hF) != 0) lead = k;
    for (int k = lead; k >= 0; k--) begin
      int d = int'((w >> (4*k)) & 24'hF);
      r.push_back(d < 10 ? 8'(8'h30 + d) : 8'h3F);
    end
`ifdef BCD_ASCII_CRLF_EN
    r.push_back(8'h0D);
    r.push_back(8'h0A);
`endif
    return r;
  endfunction

  // Per-cycle compare against the model, then advance the model for the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_m_char", m_char, 8'h00);
        chk("rst_m_last", m_last, 0);
      end else begin
        chk("s_ready", s_ready, q.size() == 0);
        chk("busy", busy, q.size() != 0);
        chk("m_valid", m_valid, q.size() != 0);
        if (q.size() != 0) begin
          chk("m_char", m_char, q[0]);
          chk("m_last", m_last, q.size() == 1);
        end
        if (q.size() == 0) begin
          if (s_valid) q = build(s_bcd);
        end else if (m_ready) begin
          log_chars.push_back(q[0]);
          log_last.push_back(q.size() == 1);
          void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic rdy(input int mode, input int i);
    logic r;
    case (mode)
      0:       r = 1'b1;
      1:       r = (i % 3 == 0);
      default: r = ($urandom_range(0, 3) != 0);
    endcase
    return r;
  endfunction

  task automatic run_word(input logic [23:0] w, input int mode, input bit hold,
                          output int cycles);
    logic got;
    int   n = 0;
    log_chars.delete();
    log_last.delete();
    s_bcd   = w;
    s_valid = 1'b1;
    do begin
      m_ready = rdy(mode, n);
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 100);
    if (!got) chk("capture_timeout", 1, 0);
    if (!hold) s_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 300) begin
      m_ready = rdy(mode, cycles);
      @(posedge clk);
      #1;
      cycles++;
    end
    if (busy) chk("word_timeout", 1, 0);
    s_valid = 1'b0;
  endtask

  task automatic check_log(input string name, input bq_t exp);
    chk({name, "_len"}, log_chars.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < log_chars.size()) chk(name, log_chars[i], exp[i]);
    if (log_last.size() != 0) chk({name, "_last"}, log_last[log_last.size()-1], 1);
  endtask

  function automatic logic [23:0] rand_word();
    logic [23:0] w = 24'h0;
    int r;
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 15);
      if (r < 5)       w[4*k +: 4] = 4'h0;
      else if (r < 14) w[4*k +: 4] = 4'($urandom_range(1, 9));
      else             w[4*k +: 4] = 4'($urandom_range(10, 15));
    end
    return w >> (4 * $urandom_range(0, 5));
  endfunction

  initial begin
    bq_t e;
    int  cyc;
    int  extra;
`ifdef BCD_ASCII_CRLF_EN
    extra = 2;
`else
    extra = 0;
`endif
    rst_n = 1'b0; s_bcd = 24'h0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_word(24'h000123, 0, 1'b0, cyc);
    e = '{8'h31, 8'h32, 8'h33};
`ifdef BCD_ASCII_CRLF_EN
    e.push_back(8'h0D); e.push_back(8'h0A);
`endif
    check_log("lead_zeros", e);
    chk("lead_zeros_cycles", cyc, 3 + extra);

    run_word(24'h000000, 0, 1'b0, cyc);
    e = '{8'h30};
`ifdef BCD_ASCII_CRLF_EN
    e.push_back(8'h0D); e.push_back(8'h0A);
`endif
    check_log("all_zero", e);
    chk("all_zero_cycles", cyc, 1 + extra);

    run_word(24'h987654, 1, 1'b0, cyc);
    e = '{8'h39, 8'h38, 8'h37, 8'h36, 8'h35, 8'h34};
`ifdef BCD_ASCII_CRLF_EN
    e.push_back(8'h0D); e.push_back(8'h0A);
`endif
    check_log("backpressure", e);

    run_word(24'h0000A5, 2, 1'b1, cyc);
    e = '{8'h3F, 8'h35};
`ifdef BCD_ASCII_CRLF_EN
    e.push_back(8'h0D); e.push_back(8'h0A);
`endif
    check_log("invalid_hold", e);

    // Mid-word reset after two characters.
    log_chars.delete();
    log_last.delete();
    @(posedge clk); #1;
    s_bcd = 24'h987654; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_sent", log_chars.size(), 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_word(24'h000042, 0, 1'b0, cyc);
    e = '{8'h34, 8'h32};
`ifdef BCD_ASCII_CRLF_EN
    e.push_back(8'h0D); e.push_back(8'h0A);
`endif
    check_log("after_rst", e);

    for (int i = 0; i < 60; i++) begin
      run_word(rand_word(), $urandom_range(0, 2), 1'($urandom_range(0, 1)), cyc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_ascii_tx.md
# bcd_ascii_tx

Serialises a packed BCD word (ones digit in the least significant nibble) into a stream of ASCII characters, most significant digit first, with leading-zero suppression. It sits directly downstream of the binary-to-BCD converter and feeds byte-oriented sinks: a UART transmitter, a character LCD writer, or a debug FIFO. It exchanges data with both neighbours through valid/ready handshakes, so it can absorb sink back-pressure without losing or duplicating digits.

## Interface
- DIGITS, default 6: number of BCD digits in the input word, minimum 1. The upstream converter output is zero-extended to 4*DIGITS bits.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_bcd  in  4*DIGITS  BCD word; digit k occupies bits [4k+3:4k].
- s_valid  in  1  s_bcd is valid.
- s_ready  out  1  block accepts a word. High only in IDLE.
- m_char  out  8  ASCII character.
- m_valid  out  1  m_char is valid.
- m_ready  in  1  sink accepts m_char.
- m_last  out  1  marks the final character of the current word; qualified by m_valid.
- busy  out  1  a word is captured and not yet fully sent.

## Operation
- The state machine has three states: IDLE, SEND, and TERM. TERM exists only with the configuration macro defined.
- **IDLE**
  - s_ready=1.
  - On s_valid&&s_ready, latch s_bcd and set the digit index idx to the most significant non-zero digit.
  - If every digit is zero, idx=0, so a single "0" is sent.
  - Load m_char with the character for digit idx, set m_valid=1, and go to SEND.
- **Digit encoding**
  - A digit in 0..9 is sent as 8'h30|digit.
  - A digit in 10..15 (invalid BCD) is sent as 8'h3F ('?').
  - Invalid digits count as non-zero for leading-zero suppression.
- **SEND**
  - On m_valid&&m_ready with idx>0: decrement idx and load the next character.
  - On a handshake with idx==0: clear m_valid and go to IDLE. With the macro defined, load CR and go to TERM instead.
- **Stability rule:** once m_valid=1, m_char and m_last hold stable until m_ready. m_valid never drops without a handshake, except on reset.
- **m_last**
  - Without the macro: m_last=1 while the idx==0 digit is presented.
  - With the macro: m_last=1 only on LF.
- busy=1 in SEND and TERM.
- **Reset:** asserting rst_n low at any time, including mid-word, returns to IDLE immediately. The partial word is dropped and nothing is replayed after reset.

## Timing
- **Reset values:** s_ready=1, m_valid=0, m_char=8'h00, m_last=0, busy=0, idx=0, state=IDLE.
- **Latency:** a word captured at edge T presents its first character with m_valid=1 at T+1.
- **Throughput:** with m_ready held high, one character per cycle. A word of n sent characters occupies n cycles in SEND, plus 1 cycle in IDLE before the next capture.
- **Back-pressure:** m_ready low freezes all state and outputs.
- **No overlap:** s_ready is a pure decode of state==IDLE. A new s_valid during SEND/TERM waits; the block never captures while busy.
- **idx arithmetic:** width $clog2(DIGITS), minimum 1 bit. idx never wraps; it stops at 0.

## Configuration
- BCD_ASCII_CRLF_EN
- **Defined:** after the ones digit, send 8'h0D then 8'h0A in state TERM, one per handshake. m_last is asserted on 8'h0A; after the LF handshake, go to IDLE. A word of n digits then yields n+2 characters.
- **Undefined:** no TERM state and no terminator characters; m_last is asserted on the ones digit.

## Structure
- Package bcd_ascii_pkg holds:
  - the state enum typedef (IDLE, SEND, TERM);
  - constants ASCII_ZERO=8'h30, ASCII_ERR=8'h3F, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - function digit_to_ascii(logic [3:0]) returning logic [7:0].
- Sub-module lead_digit_enc(DIGITS): a combinational priority encoder from a BCD word to the index of its most significant non-zero nibble, with output 0 for an all-zero word. It is instantiated once, on s_bcd.

## Test plan
- **Leading zeros:** DIGITS=6, s_bcd=24'h000123, m_ready=1 → chars 0x31,0x32,0x33 on consecutive cycles starting 1 cycle after capture; m_last on 0x33 (macro off).
- **All zeros:** s_bcd=0 → a single 0x30 with m_last=1. With the macro on → 0x30,0x0D,0x0A with m_last on 0x0A.
- **Back-pressure:** s_bcd=24'h987654, m_ready toggling 1,0,0,1,… → all six chars 0x39..0x34 in order; m_char stable while m_ready=0; no drops or duplicates.
- **Invalid digit:** s_bcd=24'h0000A5 → 0x3F,0x35. s_valid held during SEND → s_ready=0 and no capture until the last handshake completes.
- **Mid-word reset:** pulse rst_n low after 2 of 6 chars → m_valid=0, s_ready=1, busy=0 immediately; the next word is sent from its first digit.
